agp32_mem_responder: RTL
========================

Name: agp32_mem_responder

Overview:
- Memory-side responder for the agp32 processor memory interface; the other end of the processor's command/ready handshake.
- Decodes the 3-bit command and services instruction fetches and data reads/writes from an internal word array.
- Models a one-entry data-cache tag for `hit`, with variable latency, and acknowledges interrupt requests.
- Used as the simulation/FPGA memory model behind the processor wrapper.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array.
- MISS_LAT, 4, cycles from command acceptance to `ready` on a data miss (≥HIT_LAT).
- HIT_LAT, 1, cycles from acceptance to `ready` on a data hit or fetch-only access (≥1).
- IRQ_LAT, 2, cycles from sampling `interrupt_req` high to the `interrupt_ack` pulse (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- command  in  3  0 idle, 1 fetch, 2 data read, 3 data write, 4 fetch+read, 5 fetch+write, 6/7 illegal.
- inst_addr  in  32  fetch byte address; bits [1:0] ignored.
- data_addr  in  32  data byte address; bits [1:0] ignored.
- data_wdata  in  32  write data.
- data_wstrb  in  4  byte enables; bit i selects byte lane [8i+7:8i].
- interrupt_req  in  1  level request from the processor.
- mem_start_ready  out  1  high when able to accept a command.
- ready  out  1  high when the last command is complete and outputs are valid.
- hit  out  1  data access hit the tag.
- error  out  2  00 ok, 01 address out of range, 10 illegal command.
- data_rdata  out  32  read data.
- inst_rdata  out  32  fetched instruction.
- interrupt_ack  out  1  one-cycle acknowledge pulse.

Behaviour:
- Reset values (async, rst_n low): mem_start_ready=1, ready=1, hit=0, error=00, data_rdata=0, inst_rdata=0, interrupt_ack=0, tag invalid, FSM in IDLE. Array contents are not cleared.
- Acceptance: at a rising edge in IDLE with command≠0, the block latches command, word indices (addr[31:2]), wdata and wstrb.
  - Same edge: mem_start_ready←0, ready←0, FSM→WAIT.
  - Counter loaded with L−1.
- Latency L:
  - Illegal command or fetch-only (1): HIT_LAT.
  - Data commands (2–5): HIT_LAT if tag valid and data word index equals the tag, else MISS_LAT.
- WAIT: counter decrements each edge. At the edge where it is 0:
  - Access performed; outputs updated; ready←1, mem_start_ready←1; FSM→IDLE.
  - For acceptance at edge T, ready is high after edge T+L.
- command=0 in IDLE: no state change; ready and all data outputs hold their values.
- Range check: a word index ≥ 2^DEPTH_LOG2 is out of range.
  - Out-of-range fetch: inst_rdata=0. Out-of-range data access: data_rdata=0, no write.
  - Either case gives error=01.
- Error priority: illegal command (10) over range error (01) over ok (00). Illegal commands perform no access, leave the tag unchanged, and return zero data.
- Write (3/5):
  - Byte lanes with wstrb set are updated; data_rdata = the merged word after the write.
  - wstrb=0000 is legal and leaves memory unchanged.
- Fetch+data (4/5): both accesses complete in the same completion cycle.
- hit:
  - Registered at completion; 1 only for in-range data commands that hit.
  - 0 for fetch-only and illegal commands.
- Tag: after any in-range data command the tag becomes that word index and is marked valid. Out-of-range accesses do not update it.
- Commands presented while WAIT (mem_start_ready=0) are ignored.
- Interrupt FSM, independent of the memory FSM: IRQ_IDLE → IRQ_COUNT → IRQ_ACK → IRQ_HOLD.
  - IRQ_IDLE: interrupt_req sampled high → IRQ_COUNT, counter = IRQ_LAT−1.
  - IRQ_COUNT: counts to 0, then the next state is IRQ_ACK, where interrupt_ack=1 for exactly one cycle.
  - IRQ_HOLD: no further ack until interrupt_req is sampled low, then return to IRQ_IDLE.
- Reset mid-operation: the pending access is aborted with no memory write, and the tag is invalidated.

Test Plan:
- Reset, then cmd=3, data_addr=0x10, wdata=0xDEADBEEF, wstrb=1111 (tag invalid) → mem_start_ready falls at the acceptance edge; ready rises 4 edges later; error=00, hit=0; word 4 = 0xDEADBEEF.
- Then cmd=2 at 0x13 → HIT_LAT=1: ready after 1 edge, hit=1, data_rdata=0xDEADBEEF.
- cmd=3, data_addr=0x10, wdata=0x000000AA, wstrb=0001, then cmd=2 at 0x10 → data_rdata=0xDEADBEAA.
- cmd=4, inst_addr=0x10, data_addr=0x1000 (DEPTH_LOG2=10) → error=01, data_rdata=0, inst_rdata=0xDEADBEAA, hit=0, latency 4; the following cmd=2 at 0x10 still hits.
- cmd=7 → ready after 1 edge, error=10, no memory change. Also: pulse rst_n low during WAIT of a write → no write occurs; outputs return to reset values; the next read misses.
- interrupt_req held high 10 cycles → exactly one interrupt_ack pulse, 2 cycles after first sampled; drop req and raise again → a second pulse.

Source files
------------

// File: rtl/agp32_mem_responder.sv
// Memory-side responder for the agp32 command/ready handshake: fetch, data read/write, 1-entry tag, IRQ ack.
// Latency: HIT_LAT cycles (tag hit, fetch-only, illegal) or MISS_LAT cycles (data miss) from acceptance to ready.
// Backpressure: mem_start_ready low while a command is in flight; commands presented then are ignored.
// Ports: clk/rst_n; command, inst_addr, data_addr, data_wdata, data_wstrb, interrupt_req in;
//        mem_start_ready, ready, hit, error, data_rdata, inst_rdata, interrupt_ack out.
module agp32_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int MISS_LAT   = 4,
  parameter int HIT_LAT    = 1,
  parameter int IRQ_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] inst_addr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  input  logic        interrupt_req,
  output logic        mem_start_ready,
  output logic        ready,
  output logic        hit,
  output logic [1:0]  error,
  output logic [31:0] data_rdata,
  output logic [31:0] inst_rdata,
  output logic        interrupt_ack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, WAIT} mem_state_t;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_COUNT, IRQ_ACK, IRQ_HOLD} irq_state_t;

  logic [31:0] mem [0:DEPTH-1];

  mem_state_t  state;
  logic [7:0]  cnt;
  logic [2:0]  cmd_q;
  logic [29:0] iidx_q, didx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        hit_q;
  logic        tag_vld;
  logic [29:0] tag;

  irq_state_t  irq_state;
  logic [7:0]  irq_cnt;

  // Byte-offset bits carry no meaning for a word array.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, inst_addr[1:0], data_addr[1:0]};

  // Decode of the command being offered at the input.
  logic        in_data, in_illegal, in_hit;
  logic [29:0] in_didx;
  assign in_didx    = data_addr[31:2];
  assign in_data    = (command >= 3'd2) && (command <= 3'd5);
  assign in_illegal = (command[2:1] == 2'b11);
  assign in_hit     = in_data && tag_vld && (tag == in_didx);

  // Decode of the command in flight, used at completion.
  logic c_fetch, c_data, c_write, c_illegal, i_ok, d_ok, done, mem_we;
  logic [31:0] d_word, i_word, merged;
  assign c_fetch   = (cmd_q == 3'd1) || (cmd_q == 3'd4) || (cmd_q == 3'd5);
  assign c_data    = (cmd_q >= 3'd2) && (cmd_q <= 3'd5);
  assign c_write   = (cmd_q == 3'd3) || (cmd_q == 3'd5);
  assign c_illegal = (cmd_q[2:1] == 2'b11);
  assign i_ok      = (iidx_q >> DEPTH_LOG2) == '0;
  assign d_ok      = (didx_q >> DEPTH_LOG2) == '0;
  assign done      = (state == WAIT) && (cnt == 8'd0);
  assign d_word    = mem[didx_q[DEPTH_LOG2-1:0]];
  assign i_word    = mem[iidx_q[DEPTH_LOG2-1:0]];

  always_comb begin
    merged = d_word;
    for (int i = 0; i < 4; i++)
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end

  // state is reset asynchronously, so a reset during WAIT suppresses the write.
  assign mem_we = done && c_write && d_ok;

  always_ff @(posedge clk) begin
    if (mem_we) mem[didx_q[DEPTH_LOG2-1:0]] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      cmd_q           <= '0;
      iidx_q          <= '0;
      didx_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      hit_q           <= 1'b0;
      tag_vld         <= 1'b0;
      tag             <= '0;
      mem_start_ready <= 1'b1;
      ready           <= 1'b1;
      hit             <= 1'b0;
      error           <= 2'b00;
      data_rdata      <= '0;
      inst_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (command != 3'd0) begin
            cmd_q           <= command;
            iidx_q          <= inst_addr[31:2];
            didx_q          <= in_didx;
            wdata_q         <= data_wdata;
            wstrb_q         <= data_wstrb;
            hit_q           <= in_hit;
            cnt             <= (in_illegal || !in_data || in_hit) ? 8'(HIT_LAT - 1)
                                                                  : 8'(MISS_LAT - 1);
            mem_start_ready <= 1'b0;
            ready           <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            ready           <= 1'b1;
            mem_start_ready <= 1'b1;
            state           <= IDLE;
            hit             <= hit_q && d_ok;
            if (c_illegal)
              error <= 2'b10;
            else if ((c_fetch && !i_ok) || (c_data && !d_ok))
              error <= 2'b01;
            else
              error <= 2'b00;
            if (c_illegal) begin
              data_rdata <= '0;
              inst_rdata <= '0;
            end else begin
              if (c_fetch) inst_rdata <= i_ok ? i_word : 32'd0;
              if (c_data) begin
                data_rdata <= !d_ok ? 32'd0 : (c_write ? merged : d_word);
                if (d_ok) begin
                  tag     <= didx_q;
                  tag_vld <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Interrupt acknowledge: one pulse per request level, IRQ_LAT cycles after first sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_state     <= IRQ_IDLE;
      irq_cnt       <= '0;
      interrupt_ack <= 1'b0;
    end else begin
      case (irq_state)
        IRQ_IDLE: begin
          interrupt_ack <= 1'b0;
          if (interrupt_req) begin
            irq_cnt   <= 8'(IRQ_LAT - 1);
            irq_state <= IRQ_COUNT;
          end
        end
        IRQ_COUNT: begin
          if (irq_cnt == 8'd0) begin
            interrupt_ack <= 1'b1;
            irq_state     <= IRQ_ACK;
          end else begin
            irq_cnt <= irq_cnt - 8'd1;
          end
        end
        IRQ_ACK: begin
          interrupt_ack <= 1'b0;
          irq_state     <= IRQ_HOLD;
        end
        IRQ_HOLD: begin
          interrupt_ack <= 1'b0;
          if (!interrupt_req) irq_state <= IRQ_IDLE;
        end
        default: irq_state <= IRQ_IDLE;
      endcase
    end
  end

endmodule
